// File: rtl/boid_pixel_reader_pkg.sv
// boid_pixel_reader shared constants and types.
// Raster geometry and display RAM address helpers.
package boid_pixel_reader_pkg;

  localparam int VIDEO_WIDTH = 640;
  localparam int VIDEO_HEIGHT = 480;
  localparam int PIXEL_COUNT =
    VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int PIXEL_ADDRESS_WIDTH = 20;

  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int BASE_W = 19;

  typedef logic [PIXEL_ADDRESS_WIDTH-1:0]
    pix_addr_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    logic in_range;
    logic last;
  } sideband_t;

  localparam int SIDEBAND_W = $bits(sideband_t);

  // y*640 built from two shifts; exact for any 9-bit y
  function automatic logic [BASE_W-1:0] row_base(
    input logic [Y_W-1:0] y
  );
    logic [BASE_W-1:0] yy;
    yy = {10'd0, y};
    return (yy << 9) + (yy << 7);
  endfunction

endpackage

// File: rtl/boid_pixel_reader_if.sv
// Display RAM read port plus the clear-write port.
// master = pixel reader, slave = display RAM.
interface boid_pixel_reader_if;
  import boid_pixel_reader_pkg::*;

  pix_addr_t boid_read_address;
  logic read_data;
  logic clear_we;
  pix_addr_t clear_addr;

  modport master (
    output boid_read_address,
    input read_data,
    output clear_we,
    output clear_addr
  );

  modport slave (
    input boid_read_address,
    output read_data,
    input clear_we,
    input clear_addr
  );

endinterface

// File: rtl/boid_pixel_reader_sync_delay.sv
// Valid-qualified register delay line.
// Each stage loads only when the stage before it is valid.
module sync_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3
) (
  input logic clock,
  input logic reset,
  input logic valid,
  input logic [WIDTH-1:0] din,
  output logic [DEPTH-1:0] stage_valid,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;

  // shift valid every clock, data only behind a valid stage
  always_ff @(posedge clock) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++)
        data[i] <= '0;
    end else begin
      vld <= {vld[DEPTH-2:0], valid};
      if (valid)
        data[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        if (vld[i-1])
          data[i] <= data[i-1];
    end
  end

  assign stage_valid = vld;
  assign dout = data[DEPTH-1];

endmodule

// File: rtl/boid_pixel_reader.sv
// Display-side reader for the 1-bit boid memory.
// 3-stage pixel pipeline, clear-on-read, frame-end pulse.
module boid_pixel_reader
  import boid_pixel_reader_pkg::*;
#(
  parameter int CLEAR_ON_READ = 1
) (
  input logic clock,
  input logic reset,
  input logic pixel_en,
  input logic [X_W-1:0] x,
  input logic [Y_W-1:0] y,
  input logic active,
  input logic hsync_in,
  input logic vsync_in,
  boid_pixel_reader_if.master ram,
  output logic isBoidInPixel,
  output logic hsync_out,
  output logic vsync_out,
  output logic active_out,
  output logic screenEnd_out
);

  sideband_t sb_in;
  sideband_t sb_s2;
  logic [SIDEBAND_W-1:0] sb_dout;
  logic [2:0] stage_valid;
  logic in_range;

  logic [X_W-1:0] x_s0;
  logic [BASE_W-1:0] base_s0;
  logic in_range_s0;
  pix_addr_t addr_s1;
  pix_addr_t addr_s2;

  logic lit;
  logic clear_we;
  pix_addr_t clear_addr;
  logic last_seen;

  // classify the incoming raster position
  always_comb begin
    in_range =
      (x < X_W'(VIDEO_WIDTH)) &&
      (y < Y_W'(VIDEO_HEIGHT));
    sb_in = '0;
    sb_in.hsync = hsync_in;
    sb_in.vsync = vsync_in;
    sb_in.active = active;
    sb_in.in_range = in_range;
    sb_in.last =
      (x == X_W'(VIDEO_WIDTH - 1)) &&
      (y == Y_W'(VIDEO_HEIGHT - 1));
  end

  sync_delay #(
    .WIDTH (SIDEBAND_W),
    .DEPTH (3)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .valid (pixel_en),
    .din (sb_in),
    .stage_valid (stage_valid),
    .dout (sb_dout)
  );

  assign sb_s2 = sideband_t'(sb_dout);

  // S0: capture column and row base
  always_ff @(posedge clock) begin
    if (reset) begin
      x_s0 <= '0;
      base_s0 <= '0;
      in_range_s0 <= 1'b0;
    end else if (pixel_en) begin
      x_s0 <= x;
      base_s0 <= row_base(y);
      in_range_s0 <= in_range;
    end
  end

  // S1/S2: linear address, forced to 0 off-screen
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_s1 <= '0;
      addr_s2 <= '0;
    end else begin
      if (stage_valid[0])
        addr_s1 <= in_range_s0 ?
          pix_addr_t'(base_s0 + BASE_W'(x_s0)) :
          '0;
      if (stage_valid[1])
        addr_s2 <= addr_s1;
    end
  end

  assign ram.boid_read_address = addr_s1;

  assign lit = ram.read_data &
               sb_s2.active &
               sb_s2.in_range;

  // output stage: pixel flag, syncs, clear, frame end
  always_ff @(posedge clock) begin
    if (reset) begin
      isBoidInPixel <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      active_out <= 1'b0;
      screenEnd_out <= 1'b0;
      clear_we <= 1'b0;
      clear_addr <= '0;
      last_seen <= 1'b0;
    end else begin
      clear_we <= 1'b0;
      clear_addr <= '0;
      screenEnd_out <= 1'b0;
      if (stage_valid[2]) begin
        isBoidInPixel <= lit;
        hsync_out <= sb_s2.hsync;
        vsync_out <= sb_s2.vsync;
        active_out <= sb_s2.active;
        if (CLEAR_ON_READ != 0 && lit) begin
          clear_we <= 1'b1;
          clear_addr <= addr_s2;
        end
        screenEnd_out <= sb_s2.last &
                         sb_s2.active &
                         ~last_seen;
        last_seen <= sb_s2.last & sb_s2.active;
      end
    end
  end

  assign ram.clear_we = clear_we;
  assign ram.clear_addr = clear_addr;

endmodule
